// File: rtl/rv_lsu_pkg.sv
// Shared types and funct3 codes for the MEM-stage load/store unit.
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        EXC_LD_MISALIGN = 3'd0,
        EXC_ST_MISALIGN = 3'd1,
        EXC_LD_FAULT    = 3'd2,
        EXC_ST_FAULT    = 3'd3,
        EXC_ILLEGAL     = 3'd4
    } exc_cause_e;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: width legality, misalignment, byte enables,
// store-data replication and load extract/extend.
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3_i,
    input  logic             is_load_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic             legal_o,
    output logic             misaligned_o,
    output logic [NB-1:0]    be_o,
    output logic [XLEN-1:0]  wdata_o,
    input  logic [2:0]       ld_funct3_i,
    input  logic [OFF_W-1:0] ld_off_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [XLEN-1:0]  ld_data_o
);
    logic [NB-1:0]    mask;
    logic [OFF_W-1:0] align_m1;
    logic [XLEN-1:0]  sh;
    logic             fill;
    int               ld_w;

    always_comb begin
        case (funct3_i)
            F3_B, F3_H, F3_W: legal_o = 1'b1;
            F3_D:             legal_o = (XLEN == 64);
            F3_BU, F3_HU:     legal_o = is_load_i;
            F3_WU:            legal_o = is_load_i && (XLEN == 64);
            default:          legal_o = 1'b0;
        endcase

        case (funct3_i[1:0])
            2'b00: begin
                mask     = NB'(1);
                align_m1 = '0;
                wdata_o  = {NB{wdata_i[7:0]}};
            end
            2'b01: begin
                mask     = NB'(3);
                align_m1 = OFF_W'(1);
                wdata_o  = {(NB/2){wdata_i[15:0]}};
            end
            2'b10: begin
                mask     = NB'(15);
                align_m1 = OFF_W'(3);
                wdata_o  = {(NB/4){wdata_i[31:0]}};
            end
            default: begin
                mask     = '1;
                align_m1 = OFF_W'(7);
                wdata_o  = wdata_i;
            end
        endcase
        be_o         = mask << off_i;
        misaligned_o = |(off_i & align_m1);
    end

    // Load path uses the latched op, not the live EX inputs.
    always_comb begin
        sh = rdata_i >> {ld_off_i, 3'b000};
        ld_w = XLEN;
        case (ld_funct3_i[1:0])
            2'b00:   ld_w = 8;
            2'b01:   ld_w = 16;
            2'b10:   ld_w = 32;
            default: ld_w = XLEN;
        endcase
        fill = ~ld_funct3_i[2] & sh[ld_w-1];
        ld_data_o = sh;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= ld_w) ld_data_o[i] = fill;
        end
    end

endmodule

// File: rtl/rv_lsu_pipe.sv
// MEM-stage load/store unit: IDLE/REQ/WAIT handshake on a req/gnt/rvalid bus
// with timeout, misalignment and illegal-width exceptions.
module rv_lsu_pipe
    import rv_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [4:0]        ex_rd,
    output logic              lsu_busy,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [2:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;
    logic [4:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d, we_q, we_d;
    logic [NB-1:0]     be_q, be_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [XLEN-1:0]   dwdata_q, dwdata_d;
    logic              wbv_q, wbv_d;
    logic [4:0]        wbrd_q, wbrd_d;
    logic [XLEN-1:0]   wbdata_q, wbdata_d;
    logic              excv_q, excv_d;
    exc_cause_e        cause_q, cause_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;

    logic              legal, misaligned, timeout_hit;
    logic [NB-1:0]     be_gen;
    logic [XLEN-1:0]   wdata_gen, ld_data;

    rv_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i     (ex_funct3),
        .is_load_i    (ex_is_load),
        .off_i        (ex_addr[OFF_W-1:0]),
        .wdata_i      (ex_wdata),
        .legal_o      (legal),
        .misaligned_o (misaligned),
        .be_o         (be_gen),
        .wdata_o      (wdata_gen),
        .ld_funct3_i  (funct3_q),
        .ld_off_i     (addr_q[OFF_W-1:0]),
        .rdata_i      (dmem_rdata),
        .ld_data_o    (ld_data)
    );

    // Counter holds TIMEOUT-1 on the last cycle the op may still complete.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        is_load_d = is_load_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        wbv_d     = 1'b0;
        wbrd_d    = wbrd_q;
        wbdata_d  = wbdata_q;
        excv_d    = 1'b0;
        cause_d   = cause_q;
        eaddr_d   = eaddr_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && (ex_is_load || ex_is_store)) begin
                    if (!legal) begin
                        excv_d  = 1'b1;
                        cause_d = EXC_ILLEGAL;
                        eaddr_d = ex_addr;
                    end else if (misaligned) begin
                        excv_d  = 1'b1;
                        cause_d = ex_is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                        eaddr_d = ex_addr;
                    end else begin
                        state_d   = ST_REQ;
                        cnt_d     = '0;
                        funct3_d  = ex_funct3;
                        is_load_d = ex_is_load;
                        rd_d      = ex_rd;
                        addr_d    = ex_addr;
                        req_d     = 1'b1;
                        we_d      = ex_is_store;
                        be_d      = be_gen;
                        daddr_d   = {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        dwdata_d  = wdata_gen;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    excv_d  = 1'b1;
                    cause_d = is_load_q ? EXC_LD_FAULT : EXC_ST_FAULT;
                    eaddr_d = addr_q;
                end else if (dmem_gnt) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid) begin
                    state_d = ST_IDLE;
                    if (is_load_q) begin
                        wbv_d    = 1'b1;
                        wbrd_d   = rd_q;
                        wbdata_d = ld_data;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    excv_d  = 1'b1;
                    cause_d = is_load_q ? EXC_LD_FAULT : EXC_ST_FAULT;
                    eaddr_d = addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
            rd_q      <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            wbv_q     <= 1'b0;
            wbrd_q    <= '0;
            wbdata_q  <= '0;
            excv_q    <= 1'b0;
            cause_q   <= EXC_LD_MISALIGN;
            eaddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            is_load_q <= is_load_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            wbv_q     <= wbv_d;
            wbrd_q    <= wbrd_d;
            wbdata_q  <= wbdata_d;
            excv_q    <= excv_d;
            cause_q   <= cause_d;
            eaddr_q   <= eaddr_d;
        end
    end

    assign lsu_busy   = (state_q != ST_IDLE);
    assign wb_valid   = wbv_q;
    assign wb_rd      = wbrd_q;
    assign wb_data    = wbdata_q;
    assign exc_valid  = excv_q;
    assign exc_cause  = cause_q;
    assign exc_addr   = eaddr_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_rv_lsu_pipe.sv
// Scoreboarded bench for rv_lsu_pipe: an XLEN=32 and an XLEN=64 instance share
// one stimulus/bus interface, selected by sel64.
module tb_rv_lsu_pipe;
    import rv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel64;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;

    logic        busy32, wbv32, excv32, req32, we32;
    logic [4:0]  wbrd32;
    logic [31:0] wbd32, eaddr32, daddr32, dwd32;
    logic [2:0]  cause32;
    logic [3:0]  be32;
    logic        busy64, wbv64, excv64, req64, we64;
    logic [4:0]  wbrd64;
    logic [63:0] wbd64, dwd64;
    logic [31:0] eaddr64, daddr64;
    logic [2:0]  cause64;
    logic [7:0]  be64;

    logic        lsu_busy, wb_valid, exc_valid, dmem_req, dmem_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, dmem_wdata;
    logic [31:0] exc_addr, dmem_addr;
    logic [2:0]  exc_cause;
    logic [7:0]  dmem_be;

    assign lsu_busy   = sel64 ? busy64 : busy32;
    assign wb_valid   = sel64 ? wbv64  : wbv32;
    assign exc_valid  = sel64 ? excv64 : excv32;
    assign dmem_req   = sel64 ? req64  : req32;
    assign dmem_we    = sel64 ? we64   : we32;
    assign wb_rd      = sel64 ? wbrd64 : wbrd32;
    assign wb_data    = sel64 ? wbd64  : {32'b0, wbd32};
    assign dmem_wdata = sel64 ? dwd64  : {32'b0, dwd32};
    assign exc_addr   = sel64 ? eaddr64 : eaddr32;
    assign dmem_addr  = sel64 ? daddr64 : daddr32;
    assign exc_cause  = sel64 ? cause64 : cause32;
    assign dmem_be    = sel64 ? be64 : {4'b0, be32};

    rv_lsu_pipe #(.XLEN(32), .ADDR_W(32), .TIMEOUT(16)) dut32 (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid & ~sel64), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata[31:0]), .ex_rd(ex_rd),
        .lsu_busy(busy32), .wb_valid(wbv32), .wb_rd(wbrd32), .wb_data(wbd32),
        .exc_valid(excv32), .exc_cause(cause32), .exc_addr(eaddr32),
        .dmem_req(req32), .dmem_we(we32), .dmem_be(be32), .dmem_addr(daddr32), .dmem_wdata(dwd32),
        .dmem_gnt(dmem_gnt & ~sel64), .dmem_rvalid(dmem_rvalid & ~sel64), .dmem_rdata(dmem_rdata[31:0])
    );

    rv_lsu_pipe #(.XLEN(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid & sel64), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .lsu_busy(busy64), .wb_valid(wbv64), .wb_rd(wbrd64), .wb_data(wbd64),
        .exc_valid(excv64), .exc_cause(cause64), .exc_addr(eaddr64),
        .dmem_req(req64), .dmem_we(we64), .dmem_be(be64), .dmem_addr(daddr64), .dmem_wdata(dwd64),
        .dmem_gnt(dmem_gnt & sel64), .dmem_rvalid(dmem_rvalid & sel64), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_exc;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [2:0]  cause;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e = '0;
        e.rd = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic push_exc(input logic [2:0] cause, input logic [31:0] addr);
        exp_t e;
        e = '0;
        e.is_exc = 1'b1;
        e.cause = cause;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input logic [4:0] rd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = ~ld;
        ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    endtask

    task automatic load0(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] rdata,
                         input logic [4:0] rd, input logic [63:0] exp,
                         input logic [7:0] exp_be, input logic [31:0] exp_daddr);
        push_wb(rd, exp);
        issue(1'b1, f3, a, 64'd0, rd);
        check("ld_req", 64'(dmem_req), 64'd1);
        check("ld_we", 64'(dmem_we), 64'd0);
        check("ld_be", 64'(dmem_be), 64'(exp_be));
        check("ld_daddr", 64'(dmem_addr), 64'(exp_daddr));
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        dmem_rdata = rdata; dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("ld_wb_lat", 64'(wb_valid), 64'd1);
        check("ld_busy_done", 64'(lsu_busy), 64'd0);
        tick();
    endtask

    task automatic store0(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd,
                          input logic [7:0] exp_be, input logic [31:0] exp_daddr,
                          input logic [63:0] exp_wd);
        issue(1'b0, f3, a, wd, 5'd0);
        check("st_req", 64'(dmem_req), 64'd1);
        check("st_we", 64'(dmem_we), 64'd1);
        check("st_be", 64'(dmem_be), 64'(exp_be));
        check("st_daddr", 64'(dmem_addr), 64'(exp_daddr));
        check("st_wdata", dmem_wdata, exp_wd);
        check("st_busy1", 64'(lsu_busy), 64'd1);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        check("st_req_drop", 64'(dmem_req), 64'd0);
        check("st_busy2", 64'(lsu_busy), 64'd1);
        dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("st_busy_done", 64'(lsu_busy), 64'd0);
        check("st_no_wb", 64'(wb_valid), 64'd0);
        tick();
    endtask

    task automatic bad_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [2:0] cause);
        push_exc(cause, a);
        issue(ld, f3, a, 64'd0, 5'd1);
        check("bad_exc_now", 64'(exc_valid), 64'd1);
        check("bad_no_req", 64'(dmem_req), 64'd0);
        check("bad_no_busy", 64'(lsu_busy), 64'd0);
        tick();
        check("bad_no_req2", 64'(dmem_req), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(lsu_busy), 64'd0);
        check({tag, "_req"}, 64'(dmem_req), 64'd0);
        check({tag, "_we"}, 64'(dmem_we), 64'd0);
        check({tag, "_be"}, 64'(dmem_be), 64'd0);
        check({tag, "_daddr"}, 64'(dmem_addr), 64'd0);
        check({tag, "_dwdata"}, dmem_wdata, 64'd0);
        check({tag, "_wbv"}, 64'(wb_valid), 64'd0);
        check({tag, "_wbrd"}, 64'(wb_rd), 64'd0);
        check({tag, "_wbdata"}, wb_data, 64'd0);
        check({tag, "_excv"}, 64'(exc_valid), 64'd0);
        check({tag, "_cause"}, 64'(exc_cause), 64'd0);
        check({tag, "_eaddr"}, 64'(exc_addr), 64'd0);
    endtask

    // Every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (wb_valid || exc_valid)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {62'b0, exc_valid, wb_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_kind", 64'(exc_valid), 64'(e.is_exc));
                if (e.is_exc) begin
                    check("sb_cause", 64'(exc_cause), 64'(e.cause));
                    check("sb_eaddr", 64'(exc_addr), 64'(e.addr));
                end else begin
                    check("sb_rd", 64'(wb_rd), 64'(e.rd));
                    check("sb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; sel64 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 64'd0; ex_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        repeat (2) tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // XLEN=32 zero-wait accesses
        store0(F3_B, 32'h103, 64'h1234_56AB, 8'h08, 32'h100, 64'hABAB_ABAB);
        load0(F3_B,  32'h102, 64'h0080_0000, 5'd5, 64'hFFFF_FF80, 8'h04, 32'h100);
        load0(F3_BU, 32'h102, 64'h0080_0000, 5'd6, 64'h0000_0080, 8'h04, 32'h100);
        load0(F3_HU, 32'h102, 64'hBEEF_0000, 5'd0, 64'h0000_BEEF, 8'h0C, 32'h100);
        load0(F3_H,  32'h102, 64'h8001_0000, 5'd9, 64'hFFFF_8001, 8'h0C, 32'h100);
        store0(F3_H, 32'h006, 64'h0000_C0DE, 8'h0C, 32'h004, 64'hC0DE_C0DE);

        // Exceptions without bus access
        bad_op(1'b1, F3_W,  32'h101, 3'd0);
        bad_op(1'b0, F3_H,  32'h003, 3'd1);
        bad_op(1'b1, F3_D,  32'h100, 3'd4);
        bad_op(1'b0, F3_BU, 32'h100, 3'd4);
        bad_op(1'b1, F3_WU, 32'h100, 3'd4);

        // Wait states: 3 cycles without gnt, then 2 cycles without rvalid
        push_wb(5'd7, 64'hCAFE_F00D);
        issue(1'b1, F3_W, 32'h200, 64'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            check("ws_req_hold", 64'(dmem_req), 64'd1);
            check("ws_addr_hold", 64'(dmem_addr), 64'h200);
            tick();
        end
        dmem_gnt = 1'b1;
        check("ws_req_at_gnt", 64'(dmem_req), 64'd1);
        check("ws_be_hold", 64'(dmem_be), 64'h0F);
        tick(); dmem_gnt = 1'b0;
        check("ws_req_dropped", 64'(dmem_req), 64'd0);
        issue(1'b1, F3_W, 32'h240, 64'd0, 5'd8);
        tick();
        check("ws_still_busy", 64'(lsu_busy), 64'd1);
        dmem_rdata = 64'hCAFE_F00D; dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("ws_wb_lat", 64'(wb_valid), 64'd1);
        tick();

        // Load timeout without gnt, then a late response
        push_exc(3'd2, 32'h300);
        issue(1'b1, F3_W, 32'h300, 64'd0, 5'd3);
        repeat (15) tick();
        check("to_req_before", 64'(dmem_req), 64'd1);
        check("to_no_exc_early", 64'(exc_valid), 64'd0);
        tick();
        check("to_exc", 64'(exc_valid), 64'd1);
        check("to_req_dropped", 64'(dmem_req), 64'd0);
        check("to_busy_low", 64'(lsu_busy), 64'd0);
        dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        tick();

        // Store timeout after gnt
        push_exc(3'd3, 32'h500);
        issue(1'b0, F3_W, 32'h500, 64'h1111_2222, 5'd0);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        repeat (14) tick();
        check("sto_busy_before", 64'(lsu_busy), 64'd1);
        tick();
        check("sto_exc", 64'(exc_valid), 64'd1);
        tick();

        // rvalid on the timeout cycle completes normally
        push_wb(5'd4, 64'h1357_9BDF);
        issue(1'b1, F3_W, 32'h400, 64'd0, 5'd4);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        repeat (14) tick();
        dmem_rdata = 64'h1357_9BDF; dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("tc_wb", 64'(wb_valid), 64'd1);
        check("tc_no_exc", 64'(exc_valid), 64'd0);
        tick();

        // Reset while in WAIT, then a stale response
        issue(1'b1, F3_W, 32'h600, 64'd0, 5'd2);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        reset = 1'b1; tick();
        check_all_zero("midrst");
        reset = 1'b0;
        dmem_rdata = 64'hDEAD_BEEF; dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("midrst_no_wb", 64'(wb_valid), 64'd0);
        check("midrst_idle", 64'(lsu_busy), 64'd0);
        tick();
        load0(F3_W, 32'h604, 64'h7654_3210, 5'd2, 64'h7654_3210, 8'h0F, 32'h604);

        // XLEN=64 instance
        sel64 = 1'b1;
        tick();
        load0(F3_D,  32'h1008, 64'h0123_4567_89AB_CDEF, 5'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 32'h1008);
        load0(F3_WU, 32'h100C, 64'h8000_0001_DEAD_BEEF, 5'd4, 64'h0000_0000_8000_0001, 8'hF0, 32'h1008);
        load0(F3_W,  32'h100C, 64'h8000_0001_DEAD_BEEF, 5'd5, 64'hFFFF_FFFF_8000_0001, 8'hF0, 32'h1008);
        load0(F3_B,  32'h1007, 64'h9000_0000_0000_0000, 5'd6, 64'hFFFF_FFFF_FFFF_FF90, 8'h80, 32'h1000);
        store0(F3_H, 32'h1006, 64'h0000_BEEF, 8'hC0, 32'h1000, 64'hBEEF_BEEF_BEEF_BEEF);
        store0(F3_D, 32'h1010, 64'hA5A5_0000_1234_5678, 8'hFF, 32'h1010, 64'hA5A5_0000_1234_5678);
        bad_op(1'b1, F3_D, 32'h1004, 3'd0);
        bad_op(1'b0, F3_W, 32'h1002, 3'd1);

        repeat (3) tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_lsu_pipe.md
# rv_lsu_pipe

Parametrised load/store unit for the MEM stage of the 5-stage RV32I pipeline, replacing the combinational load/store handling with a handshaked, multi-cycle memory port. Accepts one memory operation from EX/MEM, generates byte enables and lane-replicated write data, drives a req/gnt/rvalid data-memory bus with arbitrary wait states, and sign- or zero-extends load data for writeback. Adds what the single-cycle path lacks: XLEN of 32 or 64, misalignment and illegal-width detection, a bus timeout with access-fault reporting, and a stall output for the pipeline.

## Interface
Parameters:
- XLEN, 32, data width; 32 or 64 only
- ADDR_W, 32, byte address width
- TIMEOUT, 16, max cycles in REQ+WAIT before access fault; ≥2

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  memory op presented this cycle
- ex_is_load / ex_is_store  in  1 each  op kind, one-hot when ex_valid
- ex_funct3  in  3  width/sign code, instr[14:12]
- ex_addr  in  ADDR_W  effective address (rv1+imm)
- ex_wdata  in  XLEN  store data (rv2)
- ex_rd  in  5  load destination
- lsu_busy  out  1  op in flight; pipeline stalls
- wb_valid  out  1  one-cycle load-result pulse
- wb_rd  out  5  load destination
- wb_data  out  XLEN  extended load data
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  3  0 load misaligned, 1 store misaligned, 2 load access fault, 3 store access fault, 4 illegal width
- exc_addr  out  ADDR_W  faulting address
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_be  out  XLEN/8  byte enables
- dmem_addr  out  ADDR_W  XLEN/8-aligned address
- dmem_wdata  out  XLEN  lane-replicated data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response / store ack
- dmem_rdata  in  XLEN  load data

## Operation
- FSM: IDLE, REQ, WAIT.
- IDLE + ex_valid + (load|store): decode funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD and 110 LWU only when XLEN=64. Stores: 000/001/010, 011 only when XLEN=64. Anything else is illegal width → cause 4.
- Misaligned (addr not a multiple of access size) → cause 0/1. On illegal width or misalignment: no bus access, exc pulse next cycle, stay IDLE.
- Otherwise latch op, clear timeout counter, go REQ.
- REQ: dmem_req=1 with stable addr/we/be/wdata. On gnt → WAIT; req drops next cycle.
- WAIT: on rvalid → IDLE. Loads: shift rdata right by offset·8, extend by funct3[2] (1 = zero), register into wb_data. Stores: no wb_valid.
- Byte enables: ((1<<bytes)−1) << addr[log2(XLEN/8)−1:0]. wdata: byte/half/word replicated across XLEN.
- Timeout counter increments every cycle in REQ/WAIT. Reaching TIMEOUT without rvalid → exc cause 2/3, IDLE, req dropped.
- ex_valid while busy is ignored. rvalid outside WAIT is ignored, including late responses after a timeout. gnt and rvalid in the same REQ cycle: rvalid ignored.
- rvalid in the same cycle the counter reaches TIMEOUT: rvalid wins, no exception.
- wb_valid pulses even when rd=0.

## Timing
- Reset: state IDLE; every output 0 on the cycle after reset is sampled.
- Reset mid-operation: abandons the op, no wb or exc pulse, in-flight response ignored.
- Accept at cycle N: req and busy high from N+1.
- Zero-wait bus (gnt at N+1, rvalid at N+2): wb_valid/exc at N+3, busy low at N+3.
- Exception without bus access: exc_valid at N+1; busy stays low.
- Outputs wb_*, exc_*, and dmem_* are registered. lsu_busy = (state ≠ IDLE).

## Structure
- Package rv_lsu_pkg holds:
  - lsu_state_e
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU)
  - exc_cause_e
- Sub-module rv_lsu_align: combinational alignment, holding be/wdata generation, misalignment check and load extract/extend, parametrised by XLEN.

## Test plan
- XLEN=32, SB addr 0x103, wdata 0x1234_56AB, zero-wait → be=1000, wdata 0xABABABAB, dmem_addr 0x100, no wb_valid, busy high for exactly 2 cycles.
- LB 0x102 with rdata 0x00_80_00_00 → wb_data 0xFFFFFF80. Same access as LBU → 0x00000080. LHU 0x102 with rdata 0xBEEF_0000 → 0x0000BEEF.
- LW 0x101 → exc cause 0, exc_addr 0x101 at N+1, dmem_req never high. SH 0x003 → cause 1. funct3=011 at XLEN=32 → cause 4.
- gnt held low for 3 cycles then rvalid after 2 more → req stable throughout, wb_valid 1 cycle after rvalid. No gnt for TIMEOUT=16 cycles → cause 2, late rvalid ignored. rvalid on the timeout cycle → normal completion.
- XLEN=64, LD 0x1008 → be=0xFF, full rdata returned. LWU 0x100C with rdata[63:32]=0x8000_0001 → 0x0000_0000_8000_0001.
- reset asserted in WAIT, then rvalid → no wb_valid, state IDLE, all outputs 0. A new LW afterwards completes normally.
